// File: rtl/spiflash_arb.sv
// Two-port read arbiter in front of spimemio: boots by reading a bank-select word,
// then serves round-robin reads with the top address bit flipped by the active bank.
module spiflash_arb #(
  parameter logic [23:0] BANK_SEL_ADDR  = 24'hFE0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        bus_clk,
  input  logic        bus_reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bank,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1024) ? $clog2(TIMEOUT_CYCLES) : 10;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {BOOT, IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          last_grant, grant, gnt_next, any_req, timeout, boot_hit;
  logic [23:0]   sel_addr;

  assign any_req  = req0_valid | req1_valid;
  // Tie goes to whoever was not served last; a lone requester always wins.
  assign gnt_next = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign sel_addr = gnt_next ? req1_addr : req0_addr;
  assign timeout  = (cnt == TO_LAST);
  // The first BOOT cycle after reset has no request outstanding yet.
  assign boot_hit = mem_valid & mem_ready;

  always_ff @(posedge bus_clk or posedge bus_reset) begin
    if (bus_reset) state <= BOOT;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT: if (boot_hit || timeout)  state_next = IDLE;
      IDLE: if (any_req)              state_next = BUSY;
      BUSY: if (mem_ready || timeout) state_next = DONE;
      DONE:                           state_next = IDLE;
      default:                        state_next = BOOT;
    endcase
  end

  always_ff @(posedge bus_clk or posedge bus_reset) begin
    if (bus_reset) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
      bank       <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
    end else begin
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
      case (state)
        BOOT: begin
          cnt       <= cnt + 1'b1;
          mem_valid <= 1'b1;
          mem_addr  <= BANK_SEL_ADDR;
          if (boot_hit) begin
            bank      <= mem_rdata[0];
            boot_done <= 1'b1;
            mem_valid <= 1'b0;
          end else if (timeout) begin
            bank      <= 1'b0;
            boot_done <= 1'b1;
            boot_err  <= 1'b1;
            mem_valid <= 1'b0;
          end
        end
        IDLE: if (any_req) begin
          grant      <= gnt_next;
          last_grant <= gnt_next;
          cnt        <= '0;
          mem_valid  <= 1'b1;
          mem_addr   <= {sel_addr[23] ^ bank, sel_addr[22:0]};
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem_ready || timeout) begin
            mem_valid <= 1'b0;
            // A late mem_ready still beats the timeout in the same cycle.
            if (grant) begin
              req1_ready <= 1'b1;
              req1_rdata <= mem_ready ? mem_rdata : 32'h0;
              req1_err   <= ~mem_ready;
            end else begin
              req0_ready <= 1'b1;
              req0_rdata <= mem_ready ? mem_rdata : 32'h0;
              req0_err   <= ~mem_ready;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
